// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: handoff FSM encodings and default depth.
package uart_tx_queue_pkg;
  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } tx_state_t;
endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Byte FIFO for the UART transmit path: storage, pointers, occupancy, flush and sticky overflow.
module uart_tx_queue_sync_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          we,
  input  logic [7:0]    wdata,
  input  logic          flush,
  input  logic          clr_ovf,
  input  logic          pop,
  output logic [7:0]    head_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          ovf_reg;
  logic          wr_en;
  logic          rd_en;
  logic          ovf_set;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign ovf       = ovf_reg;
  assign head_data = mem[rd_ptr_reg];

  // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  assign wr_en   = we & ~full & ~flush;
  assign rd_en   = pop & ~empty & ~flush;
  assign ovf_set = we & full & ~flush;

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (wr_en && !rd_en)
      count_next = count_reg + (AW+1)'(1);
    else if (rd_en && !wr_en)
      count_next = count_reg - (AW+1)'(1);
  end

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (flush)
        rd_ptr_reg <= wr_ptr_reg;
      else if (rd_en)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      if (ovf_set)
        ovf_reg <= 1'b1;
      else if (clr_ovf)
        ovf_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue between the bus write path and the UART transmitter, with a
// one-byte-at-a-time handoff FSM driving TXDATA/TXSTART.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          WE,
  input  logic [7:0]    WDATA,
  input  logic          FLUSH,
  input  logic          CLR_OVF,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   COUNT,
  output logic          OVF,
  output logic          ACTIVE,
  output logic [7:0]    TXDATA,
  output logic          TXSTART,
  input  logic          TXBUSY,
  input  logic          TXDONE
);

  tx_state_t  state_reg;
  logic [7:0] txdata_reg;
  logic       txstart_reg;
  logic [7:0] head_data;
  logic       fifo_empty;
  logic       pop;

  uart_tx_queue_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .we        (WE),
    .wdata     (WDATA),
    .flush     (FLUSH),
    .clr_ovf   (CLR_OVF),
    .pop       (pop),
    .head_data (head_data),
    .full      (FULL),
    .empty     (fifo_empty),
    .count     (COUNT),
    .ovf       (OVF)
  );

  assign EMPTY   = fifo_empty;
  assign ACTIVE  = (state_reg != S_IDLE);
  assign TXDATA  = txdata_reg;
  assign TXSTART = txstart_reg;

  // A byte leaves the queue only when the transmitter is free and no flush is pending.
  assign pop = (state_reg == S_IDLE) & ~fifo_empty & ~TXBUSY & ~FLUSH;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= S_IDLE;
      txdata_reg  <= 8'h00;
      txstart_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            txdata_reg  <= head_data;
            txstart_reg <= 1'b1;
            state_reg   <= S_START;
          end
        end
        S_START: begin
          txstart_reg <= 1'b0;
          state_reg   <= S_WAIT;
        end
        S_WAIT: begin
          if (TXDONE)
            state_reg <= S_IDLE;
        end
        default: begin
          txstart_reg <= 1'b0;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
